// File: rtl/draw_job_scheduler.sv
// Round-robin job scheduler that shares one circle engine among NREQ requesters,
// driving the engine's start/done handshake and aborting hung jobs with a watchdog.
module draw_job_scheduler #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 65536
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [3*NREQ-1:0]         req_colour,
  input  logic [8*NREQ-1:0]         req_centre_x,
  input  logic [7*NREQ-1:0]         req_centre_y,
  input  logic [8*NREQ-1:0]         req_diameter,
  output logic [NREQ-1:0]           ack,
  output logic                      ack_timeout,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      eng_start,
  output logic [2:0]                eng_colour,
  output logic [7:0]                eng_centre_x,
  output logic [6:0]                eng_centre_y,
  output logic [7:0]                eng_diameter,
  input  logic                      eng_done,
  output logic [15:0]               jobs_done
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   last, last_n;
  logic [IW-1:0]   grant_n;
  logic [IW-1:0]   winner, cand;
  logic            found;
  logic [CW-1:0]   count, count_n;
  logic            start_n, ack_to_n, busy_n;
  logic [NREQ-1:0] ack_n;
  logic [2:0]      colour_n;
  logic [7:0]      centre_x_n, diameter_n;
  logic [6:0]      centre_y_n;
  logic [15:0]     jobs_n;

  // Scan starting just after the last winner so the previous grantee gets lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = last;
    cand   = last;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(last) + i) % NREQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_n    = state;
    last_n     = last;
    grant_n    = grant_id;
    colour_n   = eng_colour;
    centre_x_n = eng_centre_x;
    centre_y_n = eng_centre_y;
    diameter_n = eng_diameter;
    start_n    = eng_start;
    ack_n      = '0;
    ack_to_n   = 1'b0;
    jobs_n     = jobs_done;
    count_n    = count;
    unique case (state)
      IDLE: begin
        // A done still high from the previous job must clear before the next grant.
        if (found && !eng_done) begin
          grant_n    = winner;
          last_n     = winner;
          colour_n   = req_colour[3*winner +: 3];
          centre_x_n = req_centre_x[8*winner +: 8];
          centre_y_n = req_centre_y[7*winner +: 7];
          diameter_n = req_diameter[8*winner +: 8];
          start_n    = 1'b1;
          count_n    = '0;
          state_n    = ISSUE;
        end
      end
      ISSUE: begin
        count_n = count + 1'b1;
        if (eng_done) begin
          start_n         = 1'b0;
          ack_n[grant_id] = 1'b1;
          jobs_n          = jobs_done + 16'd1;
          state_n         = RELEASE;
        end else if (TIMEOUT != 0 && count == CNT_LAST) begin
          start_n         = 1'b0;
          ack_n[grant_id] = 1'b1;
          ack_to_n        = 1'b1;
          state_n         = RELEASE;
        end
      end
      RELEASE: begin
        start_n = 1'b0;
        if (!eng_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last         <= IW'(NREQ - 1);
      grant_id     <= '0;
      eng_colour   <= '0;
      eng_centre_x <= '0;
      eng_centre_y <= '0;
      eng_diameter <= '0;
      eng_start    <= 1'b0;
      ack          <= '0;
      ack_timeout  <= 1'b0;
      busy         <= 1'b0;
      jobs_done    <= '0;
      count        <= '0;
    end else begin
      state        <= state_n;
      last         <= last_n;
      grant_id     <= grant_n;
      eng_colour   <= colour_n;
      eng_centre_x <= centre_x_n;
      eng_centre_y <= centre_y_n;
      eng_diameter <= diameter_n;
      eng_start    <= start_n;
      ack          <= ack_n;
      ack_timeout  <= ack_to_n;
      busy         <= busy_n;
      jobs_done    <= jobs_n;
      count        <= count_n;
    end
  end

endmodule
